// File: rtl/codec_init_sequencer_if.sv
// Handshake bundle between the init sequencer, the config-table ROM and the I2C byte sender.
interface codec_init_sequencer_if #(
  parameter int AW = 3,
  parameter int W  = 24
);
  logic          i_reinit;
  logic [AW-1:0] o_rom_addr;
  logic [W-1:0]  i_rom_data;
  logic          o_start;
  logic [W-1:0]  o_dat;
  logic          i_finished;
  logic          i_nack;
  logic          o_busy;
  logic          o_init_finish;
  logic          o_error;
  logic [AW-1:0] o_err_index;

  modport master (
    input  i_reinit, i_rom_data, i_finished, i_nack,
    output o_rom_addr, o_start, o_dat, o_busy, o_init_finish, o_error, o_err_index
  );
  modport slave (
    output i_reinit, i_rom_data, i_finished, i_nack,
    input  o_rom_addr, o_start, o_dat, o_busy, o_init_finish, o_error, o_err_index
  );
endinterface

// File: rtl/codec_init_sequencer.sv
// Walks an NUM_ENTRIES-word codec init table and hands each word to the I2C sender.
// Macro INIT_RETRY_EN: retry a NACKed word up to MAX_RETRY times before flagging an error.
module codec_init_sequencer #(
  parameter int NUM_ENTRIES = 6,
  parameter int BYTE        = 3,
  parameter int GAP_CYCLES  = 1000,
  parameter int MAX_RETRY   = 3,
  parameter int AUTO_START  = 1,
  parameter int AW          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input logic                    i_clk,
  input logic                    i_rst,
  codec_init_sequencer_if.master bus
);
  localparam int              GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [AW-1:0]   LAST     = AW'(NUM_ENTRIES - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, WAIT, GAP, DONE, ERROR} state_t;

  state_t        state, state_n;
  logic [AW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic          gap_to_start;
  logic          fin, restart, can_retry;
  logic          start_n, busy_n, finish_n, error_n;

  assign fin     = (state == WAIT) && bus.i_finished;
  assign restart = ((state == DONE) || (state == ERROR)) && bus.i_reinit;

`ifdef INIT_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry;

  assign can_retry = (retry < RW'(MAX_RETRY));

  always_ff @(posedge i_clk) begin
    if (i_rst || restart)    retry <= '0;
    else if (fin) begin
      if (!bus.i_nack)       retry <= '0;
      else if (can_retry)    retry <= retry + 1'b1;
    end
  end
`else
  // retries compiled out: every NACK is fatal
  assign can_retry = (MAX_RETRY < 0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (AUTO_START != 0 || bus.i_reinit) state_n = FETCH;
      FETCH: state_n = LOAD;
      LOAD:  state_n = START;
      START: state_n = WAIT;
      WAIT: if (bus.i_finished) begin
        if (!bus.i_nack) state_n = (cnt == LAST) ? DONE : GAP;
        else             state_n = can_retry ? GAP : ERROR;
      end
      GAP:   if (gap_cnt == GAP_LAST) state_n = gap_to_start ? START : FETCH;
      DONE, ERROR: if (bus.i_reinit) state_n = FETCH;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    start_n  = (state_n == START);
    busy_n   = !(state_n inside {IDLE, DONE, ERROR});
    finish_n = (state_n == DONE);
    error_n  = (state_n == ERROR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt               <= '0;
      gap_cnt           <= '0;
      gap_to_start      <= 1'b0;
      bus.o_start       <= 1'b0;
      bus.o_busy        <= 1'b0;
      bus.o_init_finish <= 1'b0;
      bus.o_error       <= 1'b0;
      bus.o_rom_addr    <= '0;
      bus.o_dat         <= '0;
      bus.o_err_index   <= '0;
    end else begin
      bus.o_start       <= start_n;
      bus.o_busy        <= busy_n;
      bus.o_init_finish <= finish_n;
      bus.o_error       <= error_n;
      bus.o_err_index   <= (state_n == ERROR) ? cnt : '0;
      if (state_n == FETCH) bus.o_rom_addr <= restart ? '0 : cnt;
      if (state == LOAD)    bus.o_dat      <= bus.i_rom_data[BYTE*8-1:0];
      gap_cnt <= (state == GAP && gap_cnt != GAP_LAST) ? gap_cnt + 1'b1 : '0;
      if (fin) gap_to_start <= bus.i_nack;
      if (fin && !bus.i_nack && cnt != LAST) cnt <= cnt + 1'b1;
      else if (restart)                      cnt <= '0;
    end
  end
endmodule

// File: tb/tb_codec_init_sequencer.sv
// Scoreboard bench: expected sender words are queued when a run is kicked off and popped on each o_start.
module tb_codec_init_sequencer;
  localparam int N   = 6;
  localparam int GAP = 4;
`ifdef INIT_RETRY_EN
  localparam int TRIES = 4;
  localparam int RETRY_STARTS = N + 2;
  localparam int RETRY_ERR = 0, RETRY_FIN = 1, RETRY_IDX = 0;
`else
  localparam int TRIES = 1;
  localparam int RETRY_STARTS = 3;
  localparam int RETRY_ERR = 1, RETRY_FIN = 0, RETRY_IDX = 2;
`endif

  logic clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
  always #5 clk = ~clk;

  codec_init_sequencer_if #(.AW(3), .W(24)) ifa ();
  codec_init_sequencer_if #(.AW(1), .W(24)) ifb ();

  codec_init_sequencer #(.NUM_ENTRIES(N), .BYTE(3), .GAP_CYCLES(GAP), .MAX_RETRY(3), .AUTO_START(1))
    u_dut (.i_clk(clk), .i_rst(rst_a), .bus(ifa));
  codec_init_sequencer #(.NUM_ENTRIES(1), .BYTE(3), .GAP_CYCLES(GAP), .MAX_RETRY(3), .AUTO_START(0))
    u_one (.i_clk(clk), .i_rst(rst_b), .bus(ifb));

  int          n_chk = 0, n_pass = 0, cyc = 0;
  int          starts_a = 0, starts_b = 0;
  int          fin_cyc = -1, prev_k = -1;
  int          nack_left [N];
  bit          silent [N];
  logic [23:0] q_a [$];
  logic [23:0] q_b [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push_a(input int k, input int times);
    repeat (times) q_a.push_back(24'h340000 + 24'(k));
  endtask

  task automatic kick_a();
    fin_cyc = -1;
    ifa.i_reinit = 1'b1;
    @(negedge clk);
    ifa.i_reinit = 1'b0;
  endtask

  task automatic wait_end_a(input string tag);
    int i;
    i = 0;
    while (i < 4000 && !(ifa.o_init_finish || ifa.o_error)) begin
      @(negedge clk);
      i++;
    end
    chk(tag, i < 4000, 1);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ifa.i_rom_data <= 24'h340000 + 24'(ifa.o_rom_addr);
    ifb.i_rom_data <= 24'hC0DE00 + 24'(ifb.o_rom_addr);
  end

  always @(negedge clk) if (ifb.o_start) starts_b <= starts_b + 1;

  // I2C sender model for the 6-entry instance: answers 10 cycles after each start.
  initial begin : sender_a
    logic [23:0] exp;
    int          k;
    bit          nk;
    ifa.i_finished = 1'b0;
    ifa.i_nack     = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.o_start) begin
        starts_a++;
        exp = (q_a.size() != 0) ? q_a.pop_front() : 24'hFFFFFF;
        k   = int'(exp[7:0]) % N;
        chk("start_dat", ifa.o_dat, exp);
        chk("start_addr", ifa.o_rom_addr, exp[2:0]);
        chk("start_busy", ifa.o_busy, 1);
        if (fin_cyc >= 0) chk("gap_len", cyc - fin_cyc - 1, (k == prev_k) ? GAP : GAP + 2);
        if (!silent[k]) begin
          nk = (nack_left[k] != 0);
          if (nack_left[k] > 0) nack_left[k]--;
          repeat (9) @(negedge clk);
          chk("dat_hold", ifa.o_dat, exp);
          ifa.i_finished = 1'b1;
          ifa.i_nack     = nk;
          fin_cyc = cyc;
          prev_k  = k;
          @(negedge clk);
          ifa.i_finished = 1'b0;
          ifa.i_nack     = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s0, n;
    logic [23:0] exp_b;
    ifa.i_reinit = 1'b0;
    ifb.i_reinit = 1'b0;
    ifb.i_finished = 1'b0;
    ifb.i_nack = 1'b0;
    foreach (nack_left[i]) begin nack_left[i] = 0; silent[i] = 1'b0; end

    repeat (3) @(negedge clk);
    chk("rst_a_outs", {ifa.o_start, ifa.o_busy, ifa.o_init_finish, ifa.o_error,
                       ifa.o_rom_addr, ifa.o_dat, ifa.o_err_index}, 0);
    chk("rst_b_outs", {ifb.o_start, ifb.o_busy, ifb.o_init_finish, ifb.o_error,
                       ifb.o_rom_addr, ifb.o_dat, ifb.o_err_index}, 0);

    // auto-start run
    for (int k = 0; k < N; k++) push_a(k, 1);
    rst_a = 1'b0;
    n = 1;
    while (!ifa.o_start && n < 20) begin @(negedge clk); n++; end
    chk("first_start_cycle", n, 4);
    wait_end_a("run1_end");
    chk("run1_finish", ifa.o_init_finish, 1);
    chk("run1_busy", ifa.o_busy, 0);
    chk("run1_err", ifa.o_error, 0);
    chk("run1_starts", starts_a, N);
    chk("run1_q", q_a.size(), 0);

    // reinit from DONE, plus an ignored reinit mid-sequence
    for (int k = 0; k < N; k++) push_a(k, 1);
    s0 = starts_a;
    kick_a();
    chk("reinit_fin_drop", ifa.o_init_finish, 0);
    chk("reinit_addr", ifa.o_rom_addr, 0);
    chk("reinit_busy", ifa.o_busy, 1);
    n = 0;
    while (starts_a < s0 + 2 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    ifa.i_reinit = 1'b1;
    @(negedge clk);
    ifa.i_reinit = 1'b0;
    wait_end_a("run2_end");
    chk("run2_starts", starts_a - s0, N);
    chk("run2_finish", ifa.o_init_finish, 1);
    chk("run2_q", q_a.size(), 0);

    // entry 2 NACKed twice then ACKed
    nack_left[2] = 2;
    s0 = starts_a;
    push_a(0, 1); push_a(1, 1); push_a(2, (TRIES > 1) ? 3 : 1);
    if (TRIES > 1) for (int k = 3; k < N; k++) push_a(k, 1);
    kick_a();
    wait_end_a("retry_end");
    chk("retry_starts", starts_a - s0, RETRY_STARTS);
    chk("retry_err", ifa.o_error, RETRY_ERR);
    chk("retry_fin", ifa.o_init_finish, RETRY_FIN);
    chk("retry_idx", ifa.o_err_index, RETRY_IDX);
    chk("retry_q", q_a.size(), 0);
    nack_left[2] = 0;

    // entry 4 always NACKed
    nack_left[4] = -1;
    s0 = starts_a;
    for (int k = 0; k < 4; k++) push_a(k, 1);
    push_a(4, TRIES);
    kick_a();
    wait_end_a("exh_end");
    chk("exh_err", ifa.o_error, 1);
    chk("exh_idx", ifa.o_err_index, 4);
    chk("exh_busy", ifa.o_busy, 0);
    chk("exh_fin", ifa.o_init_finish, 0);
    chk("exh_starts", starts_a - s0, 4 + TRIES);
    repeat (50) @(negedge clk);
    chk("exh_quiet", starts_a - s0, 4 + TRIES);
    chk("exh_q", q_a.size(), 0);
    nack_left[4] = 0;

    // reset while waiting on entry 3
    silent[3] = 1'b1;
    s0 = starts_a;
    for (int k = 0; k < 4; k++) push_a(k, 1);
    kick_a();
    n = 0;
    while (starts_a < s0 + 4 && n < 1000) begin @(negedge clk); n++; end
    chk("rstmid_reached", starts_a - s0, 4);
    repeat (3) @(negedge clk);
    chk("rstmid_busy", ifa.o_busy, 1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("rstmid_outs", {ifa.o_start, ifa.o_busy, ifa.o_init_finish, ifa.o_error,
                        ifa.o_rom_addr, ifa.o_dat, ifa.o_err_index}, 0);
    silent[3] = 1'b0;
    q_a.delete();
    for (int k = 0; k < N; k++) push_a(k, 1);
    fin_cyc = -1;
    s0 = starts_a;
    rst_a = 1'b0;
    wait_end_a("rstmid_restart_end");
    chk("rstmid_starts", starts_a - s0, N);
    chk("rstmid_finish", ifa.o_init_finish, 1);
    chk("rstmid_q", q_a.size(), 0);

    // single-entry instance, manual start
    rst_b = 1'b0;
    repeat (20) @(negedge clk);
    chk("b_no_auto", starts_b, 0);
    chk("b_idle_busy", ifb.o_busy, 0);
    q_b.push_back(24'hC0DE00);
    ifb.i_reinit = 1'b1;
    @(negedge clk);
    ifb.i_reinit = 1'b0;
    n = 0;
    while (!ifb.o_start && n < 20) begin @(negedge clk); n++; end
    exp_b = (q_b.size() != 0) ? q_b.pop_front() : 24'hFFFFFF;
    chk("b_start_seen", ifb.o_start, 1);
    chk("b_dat", ifb.o_dat, exp_b);
    chk("b_addr", ifb.o_rom_addr, 0);
    repeat (3) @(negedge clk);
    ifb.i_finished = 1'b1;
    @(negedge clk);
    ifb.i_finished = 1'b0;
    chk("b_done_nogap", ifb.o_init_finish, 1);
    chk("b_busy", ifb.o_busy, 0);
    repeat (10) @(negedge clk);
    chk("b_starts", starts_b, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/codec_init_sequencer.md
Name: codec_init_sequencer

Overview:
- Parametrised successor to the fixed 6-word codec setup block: walks an external init table of NUM_ENTRIES words of BYTE bytes each.
- Hands each word to the existing I2C byte-level sender through a start/finished handshake.
- Inserts a programmable gap between writes, retries NACKed writes, reports errors, and can re-run the whole sequence on request.
- Sits between the codec-config ROM and the I2C sender, and gates the audio path via o_init_finish.

Parameters:
- NUM_ENTRIES, 6: number of table words; range 1..256.
- BYTE, 3: bytes per I2C transaction; word width is BYTE*8.
- GAP_CYCLES, 1000: idle i_clk cycles between the end of one transaction and the next fetch or retry; minimum 1.
- MAX_RETRY, 3: extra attempts per word after a NACK; used only with INIT_RETRY_EN.
- AUTO_START, 1: 1 means the sequence starts right after reset; 0 means it waits for i_reinit.
- AW, $clog2(NUM_ENTRIES) (minimum 1): derived; do not override.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_reinit  in  1  one-cycle request to (re)run the sequence from entry 0.
- o_rom_addr  out  AW  table read address.
- i_rom_data  in  BYTE*8  table word; valid 1 cycle after o_rom_addr.
- o_start  out  1  one-cycle start pulse to the I2C sender.
- o_dat  out  BYTE*8  word for the sender; stable from o_start until i_finished.
- i_finished  in  1  one-cycle pulse from the sender at the end of a transaction.
- i_nack  in  1  sampled only together with i_finished; 1 means the slave NACKed.
- o_busy  out  1  high from leaving IDLE until entering DONE or ERROR.
- o_init_finish  out  1  high in DONE.
- o_error  out  1  high in ERROR.
- o_err_index  out  AW  index of the failing entry; valid while o_error is high.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - State goes to IDLE; entry counter cnt=0; retry counter=0.
  - o_start, o_busy, o_init_finish and o_error are 0; o_rom_addr=0, o_dat=0, o_err_index=0.
  - Reset mid-transaction abandons it immediately. The sender is reset by the same i_rst.
- All outputs are registered.
- States and transitions:
  - IDLE: go to FETCH if AUTO_START=1 (first cycle after reset) or if i_reinit=1; otherwise stay.
  - FETCH (1 cycle): drive o_rom_addr=cnt.
  - LOAD (1 cycle): capture i_rom_data into o_dat.
  - START (1 cycle): o_start=1. Go to WAIT.
  - WAIT: hold o_dat. On i_finished with i_nack=0:
    - if cnt==NUM_ENTRIES-1, go to DONE;
    - otherwise cnt<=cnt+1, clear the retry counter, go to GAP with next=FETCH.
  - WAIT, on i_finished with i_nack=1: see Optional Feature.
  - GAP: count GAP_CYCLES cycles, then go to next (FETCH, or START for a retry).
  - DONE: o_init_finish=1 and cnt holds NUM_ENTRIES-1. On i_reinit: cnt<=0, go to FETCH, o_init_finish drops the next cycle.
  - ERROR: o_error=1 and o_err_index=cnt. On i_reinit: clear the error, cnt<=0, go to FETCH.
- Timing with AUTO_START=1: o_start is first high in the 4th cycle after i_rst deasserts (IDLE, FETCH, LOAD, START).
- Handshake and boundary rules:
  - i_reinit is ignored while o_busy=1.
  - i_finished outside WAIT is ignored.
  - i_finished and i_reinit in the same cycle: i_finished is processed and i_reinit is ignored.
  - Retries reuse the latched o_dat and do not refetch.
  - The cnt comparison is width-safe for NUM_ENTRIES=1 (AW=1).
  - The GAP counter width is $clog2(GAP_CYCLES+1). The counter saturates and never wraps.
  - With NUM_ENTRIES=1, the sequence goes straight to DONE after the single ACK, with no GAP.

Optional Feature:
- Macro: INIT_RETRY_EN.
- Defined, on NACK:
  - if retry counter < MAX_RETRY: increment it and go to GAP with next=START (same word);
  - otherwise go to ERROR.
- Not defined: any NACK goes directly to ERROR. MAX_RETRY and the retry counter are not synthesised.

Test Plan:
- Normal run: NUM_ENTRIES=6, GAP_CYCLES=4, ROM word k = 24'h340000+k, sender always ACKs with finished 10 cycles after start -> exactly 6 o_start pulses, o_dat values 0x340000..0x340005 in order, each stable through its finished, ≥4 idle cycles between transactions, o_init_finish=1 and o_busy=0 after the 6th finished.
- NACK retry (INIT_RETRY_EN, MAX_RETRY=3): entry 2 NACKed twice then ACKed -> entry 2 sent 3 times with an identical o_dat and no rom_addr change, sequence completes, o_error stays 0.
- Retry exhaustion: entry 4 always NACKed -> 4 starts with INIT_RETRY_EN (1 without it), then o_error=1, o_err_index=4, o_busy=0, no further o_start.
- Reinit: i_reinit in DONE -> o_init_finish=0 the next cycle, rom_addr restarts at 0, full 6-word sequence again. i_reinit pulsed mid-sequence -> no effect.
- Reset mid-transaction: assert i_rst during WAIT of entry 3 -> next cycle all outputs at reset values. With AUTO_START=1, after release the sequence restarts at entry 0.
- AUTO_START=0, NUM_ENTRIES=1: no o_start until i_reinit. After i_reinit, one o_start; on ACK go directly to DONE with no gap.
